// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state type for the 120 MHz transmit and receive paths
package uart_pkg;
   localparam int CLK_HZ = 120_000_000;
   localparam int BAUD = 12_000_000;
   localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_120m_if.sv
// uart_tx_120m_if: valid/ready byte handshake between an on-chip producer and the transmitter
interface uart_tx_120m_if;
   logic [7:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock FIFO with registered count, guarded push/pop and first-word-fall-through read
module uart_tx_fifo #(
   parameter int AW = 4,
   parameter int W = 8
) (
   input  logic m_clock,
   input  logic p_reset,
   input  logic push,
   input  logic [W-1:0] wdata,
   input  logic pop,
   output logic [W-1:0] rdata,
   output logic [AW:0] count,
   output logic full,
   output logic empty
);
   logic [W-1:0] mem [2**AW];
   logic [AW-1:0] wp, rp;
   logic push_ok, pop_ok;
   assign full = count == (AW+1)'(2**AW);
   assign empty = count == '0;
   assign push_ok = push & ~full;
   assign pop_ok = pop & ~empty;
   assign rdata = mem[rp];
   always_ff @(posedge m_clock)
      if (push_ok) mem[wp] <= wdata;
   always_ff @(posedge m_clock or posedge p_reset)
      if (p_reset) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= push_ok ? wp + 1'b1 : wp;
         rp <= pop_ok ? rp + 1'b1 : rp;
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
endmodule

// File: rtl/uart_tx_120m.sv
// uart_tx_120m: 12 Mbps 8N1 transmitter for the 120 MHz domain, FIFO-buffered, back-to-back frames
module uart_tx_120m
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_AW = 4
) (
   input  logic m_clock,
   input  logic p_reset,
   uart_tx_120m_if.slave tx,
   output logic txd,
   output logic busy,
   output logic [FIFO_AW:0] fifo_count
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   uart_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0] bit_idx, bit_nx;
   logic [7:0] shift, shift_nx, head;
   logic pop, full, empty, tick;
   uart_tx_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
      .m_clock(m_clock),
      .p_reset(p_reset),
      .push(tx.tx_valid),
      .wdata(tx.tx_data),
      .pop(pop),
      .rdata(head),
      .count(fifo_count),
      .full(full),
      .empty(empty)
   );
   assign tx.tx_ready = ~full;
   assign tick = cnt == LAST;
   always_comb begin
      state_nx = state;
      cnt_nx = tick ? '0 : cnt + 1'b1;
      bit_nx = bit_idx;
      shift_nx = shift;
      pop = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            pop = !empty;
            shift_nx = empty ? shift : head;
            state_nx = empty ? IDLE : START;
         end
         START: if (tick) begin
            bit_nx = '0;
            state_nx = DATA;
         end
         DATA: if (tick) begin
            shift_nx = shift >> 1;
            bit_nx = bit_idx + 1'b1;
            state_nx = (bit_idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
         end
         STOP: if (tick) begin
            pop = !empty;
            shift_nx = empty ? shift : head;
            state_nx = empty ? IDLE : START;
         end
      endcase
   end
   // txd is driven from the current state, so the line lags the state register by one cycle
   always_ff @(posedge m_clock or posedge p_reset)
      if (p_reset) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         txd <= 1'b1;
         busy <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         bit_idx <= bit_nx;
         shift <= shift_nx;
         txd <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
         busy <= (state != IDLE) || (fifo_count != '0);
      end
endmodule

// File: tb/tb_uart_tx_120m.sv
// tb_uart_tx_120m: directed checks of framing, FIFO flow control, async reset and line decode
module tb_uart_tx_120m;
   logic m_clock = 1'b0;
   logic p_reset = 1'b1;
   logic txd, busy;
   logic [4:0] fifo_count;
   int n_assert = 0;
   int n_fail = 0;
   uart_tx_120m_if bus ();
   uart_tx_120m #(.CLKS_PER_BIT(10), .FIFO_AW(4)) dut (
      .m_clock(m_clock),
      .p_reset(p_reset),
      .tx(bus),
      .txd(txd),
      .busy(busy),
      .fifo_count(fifo_count)
   );
   always #5 m_clock = ~m_clock;

   task automatic check(input string tag, input logic [99:0] obs, input logic [99:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge m_clock);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.tx_data = b;
      bus.tx_valid = 1'b1;
      step(1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic capture(output logic [99:0] w);
      for (int i = 0; i < 100; i++) begin
         step(1);
         w[i] = txd;
      end
   endtask

   // expected line waveform: 10 samples per bit cell, start 0, data LSB first, stop 1
   function automatic logic [99:0] exp_wave(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 100; i++) exp_wave[i] = f[i / 10];
   endfunction

   logic [99:0] w;
   logic [7:0] rx;
   logic burst [2000];
   int stalls, bad_ready, overflow, accepted, found;

   initial begin
      bus.tx_data = '0;
      bus.tx_valid = 1'b0;
      step(2);
      check("reset_txd", 100'(txd), 100'(1));
      check("reset_ready", 100'(bus.tx_ready), 100'(1));
      check("reset_busy", 100'(busy), 100'(0));
      check("reset_count", 100'(fifo_count), 100'(0));
      p_reset = 1'b0;
      step(2);

      push_byte(8'h55);
      check("t1_count_after_push", 100'(fifo_count), 100'(1));
      check("t1_busy_push_edge", 100'(busy), 100'(0));
      step(1);
      check("t1_count_after_pop", 100'(fifo_count), 100'(0));
      check("t1_txd_before_start", 100'(txd), 100'(1));
      check("t1_busy_after_pop", 100'(busy), 100'(1));
      capture(w);
      check("t1_wave_55", w, exp_wave(8'h55));
      check("t1_busy_end_stop", 100'(busy), 100'(1));
      step(1);
      check("t1_busy_fall", 100'(busy), 100'(0));
      check("t1_txd_idle", 100'(txd), 100'(1));

      step(3);
      push_byte(8'hA3);
      step(1);
      check("t2_txd_before_start", 100'(txd), 100'(1));
      capture(w);
      for (int j = 0; j < 8; j++) rx[j] = w[10 * (j + 1) + 5];
      check("t2_midbit_byte", 100'(rx), 100'(8'hA3));
      check("t2_start_level", 100'(w[5]), 100'(0));
      check("t2_stop_level", 100'(w[95]), 100'(1));
      check("t2_wave_a3", w, exp_wave(8'hA3));
      step(1);
      check("t2_after_frame", 100'(txd), 100'(1));

      step(3);
      stalls = 0;
      bad_ready = 0;
      overflow = 0;
      accepted = 0;
      fork
         begin
            logic rdy;
            for (int i = 0; i < 20; i++) begin
               bus.tx_data = 8'(i);
               bus.tx_valid = 1'b1;
               do begin
                  rdy = bus.tx_ready;
                  if (fifo_count == 5'd16 && !rdy) stalls++;
                  @(posedge m_clock);
                  #1;
                  if (fifo_count > 5'd16) overflow++;
                  if (bus.tx_ready !== (fifo_count != 5'd16)) bad_ready++;
               end while (!rdy);
               accepted++;
            end
            bus.tx_valid = 1'b0;
         end
         begin
            @(posedge m_clock);
            @(posedge m_clock);
            for (int i = 0; i < 2000; i++) begin
               @(posedge m_clock);
               #1;
               burst[i] = txd;
            end
         end
      join
      check("t3_accepted", 100'(accepted), 100'(20));
      check("t3_full_stall_seen", 100'(stalls > 0), 100'(1));
      check("t3_ready_vs_count", 100'(bad_ready), 100'(0));
      check("t3_no_overflow", 100'(overflow), 100'(0));
      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < 100; i++) w[i] = burst[100 * f + i];
         check($sformatf("t3_frame_%0d", f), w, exp_wave(8'(f)));
      end
      step(1);
      check("t3_drained_count", 100'(fifo_count), 100'(0));
      check("t3_idle_txd", 100'(txd), 100'(1));

      step(3);
      for (int i = 0; i < 6; i++) push_byte(8'h11 + 8'(i));
      check("t4_queued", 100'(fifo_count), 100'(5));
      step(40);
      check("t4_bit3_low", 100'(txd), 100'(0));
      check("t4_busy_mid", 100'(busy), 100'(1));
      p_reset = 1'b1;
      #1;
      check("t4_rst_txd", 100'(txd), 100'(1));
      check("t4_rst_count", 100'(fifo_count), 100'(0));
      check("t4_rst_busy", 100'(busy), 100'(0));
      check("t4_rst_ready", 100'(bus.tx_ready), 100'(1));
      step(2);
      p_reset = 1'b0;
      step(2);
      push_byte(8'h7E);
      step(1);
      capture(w);
      check("t4_wave_7e", w, exp_wave(8'h7E));
      step(20);
      check("t4_discarded_txd", 100'(txd), 100'(1));
      check("t4_discarded_busy", 100'(busy), 100'(0));

      step(3);
      push_byte(8'h3C);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step(1);
         if (txd == 1'b0) found = 1;
      end
      check("t5_start_found", 100'(found), 100'(1));
      step(4);
      check("t5_mid_start", 100'(txd), 100'(0));
      for (int j = 0; j < 8; j++) begin
         step(10);
         rx[j] = txd;
      end
      check("t5_rx_byte", 100'(rx), 100'(8'h3C));
      step(10);
      check("t5_mid_stop", 100'(txd), 100'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_120m.md
Name: uart_tx_120m

Overview:
- Byte-wide UART transmitter for the 120 MHz PLL clock domain; 12 Mbps, 8N1.
- Mirror of the existing 12 Mbps receive path; drives the board txd pin.
- Small internal FIFO absorbs bursts from an on-chip producer, such as echo of received bytes or a status/debug dump.
- Supports back-to-back frames with no idle gap.

Parameters:
- CLKS_PER_BIT, 10, m_clock cycles per serial bit (120 MHz / 12 Mbps); legal range 4..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- m_clock  in  1  120 MHz PLL output clock; all logic on its rising edge.
- p_reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  producer offers tx_data this cycle.
- tx_ready  out  1  FIFO can accept; transfer occurs on a rising edge where tx_valid & tx_ready.
- txd  out  1  serial line; idle high; registered output.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  FIFO_AW+1  entries currently held, 0..2**FIFO_AW.

Behaviour:
- Reset (async assert, sync release):
  - txd=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM=IDLE, FIFO pointers cleared.
  - Reset mid-frame truncates the frame: txd returns high immediately and queued bytes are discarded.
- FIFO:
  - Registered count; tx_ready = (fifo_count != depth), taken from the registered count only.
  - No combinational path from tx_valid to tx_ready.
  - Push and pop on the same edge: count unchanged, both succeed.
  - When full, a same-cycle pop does NOT raise tx_ready that cycle.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO non-empty: pop head into an 8-bit shift register, clear baud counter, go to START. Pop edge = entry edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START (stop bit of exactly CLKS_PER_BIT, no extra idle cycle); otherwise go to IDLE.
- Baud counter: width = clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when the counter equals CLKS_PER_BIT-1.
- Frame length: exactly 10*CLKS_PER_BIT cycles (100 at default).
- Latency: byte accepted at edge k with FIFO empty and FSM IDLE → count=1 after edge k, pop at edge k+1, txd low from edge k+2.
- busy = (state != IDLE) | (fifo_count != 0), registered.
- txd is a flop output (no glitches on the pin).

Decomposition:
- Shared package uart_pkg holds:
  - CLK_HZ=120_000_000, BAUD=12_000_000, CLKS_PER_BIT_DEFAULT=10.
  - Frame constants DATA_BITS=8, STOP_BITS=1.
  - FSM state typedef (2-bit encoding), to be reused by the receiver rewrite.
- One natural sub-module: uart_tx_fifo.
  - Synchronous single-clock FIFO with push/pop/count/full/empty and the same reset.
  - Instantiated once; the FSM and serializer stay in uart_tx_120m.

Test Plan:
- Single byte 0x55 pushed at edge 10:
  - txd low on cycles 12..21.
  - Data bits 1,0,1,0,1,0,1,0, each 10 cycles.
  - Stop high cycles 102..111, then IDLE; busy falls after the frame.
- Byte 0xA3:
  - Sample txd at mid-bit (offset 5 in each bit cell) and recover 0xA3 LSB first.
  - Start/stop levels 0/1; total frame 100 cycles.
- Burst of 20 bytes 0x00..0x13 with tx_valid held high:
  - tx_ready drops when count=16.
  - All 20 bytes appear in order, each frame exactly 100 cycles.
  - No idle gap between stop and next start.
  - No byte lost or duplicated.
- Simultaneous push/pop at full:
  - count stays 16, tx_ready stays 0 that cycle.
  - Next byte is accepted only after the count drops.
- p_reset asserted during bit 3 of a frame with 5 bytes queued:
  - txd=1 within the same cycle, fifo_count=0, busy=0.
  - After release, a new byte 0x7E transmits cleanly.
- Loopback: txd into the 12 Mbps receiver, send 0x3C.
  - Receiver outputs 0x3C; HEX displays show "3" and "C" patterns.
